checksum16_verify: RTL
======================

CHECKSUM16_VERIFY -- requirements
Module: checksum16_verify

Interface
REQ-001 Parameter: LEN_W, default 16, width of the packet word counter.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: bits_in  input  16  packet word; the last word of a packet is the transmitted checksum.
REQ-006 Port: bits_valid  input  1  bits_in is valid this cycle.
REQ-007 Port: bits_last  input  1  marks the final word (the checksum word) of a packet; qualified by bits_valid.
REQ-008 Port: bits_ready  output  1  block can accept a word this cycle.
REQ-009 Port: done  output  1  one-cycle pulse; the verdict is available.
REQ-010 Port: pass  output  1  1 when the folded sum of the packet equals 16'hFFFF.
REQ-011 Port: bits_out  output  16  one's complement of the folded sum; 16'h0000 on a good packet.
REQ-012 Port: word_cnt  output  LEN_W  number of words in the reported packet, checksum word included.
REQ-013 Port: len_ovf  output  1  the reported packet exceeded 2^LEN_W-1 words.

Function
REQ-014 A word SHALL be accepted only in a cycle where bits_valid=1 and bits_ready=1; bits_last without bits_valid SHALL be ignored.
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM, REPORT.
REQ-016 bits_ready SHALL be 1 in IDLE and ACCUM, and 0 in REPORT.
REQ-017 IDLE, on accept: acc <= bits_in; word count <= 1; next state is REPORT if bits_last=1, otherwise ACCUM.
REQ-018 ACCUM, on accept: acc <= one's-complement add of acc and bits_in; next state is REPORT if bits_last=1, otherwise ACCUM.
REQ-019 ACCUM with no accept: hold all state.
REQ-020 One's-complement add SHALL be performed as follows:
- s = acc + bits_in, computed 17 bits wide;
- result = s[15:0] + s[16], with the end-around carry applied in the same cycle;
- the result SHALL never exceed 16 bits.
REQ-021 On the final accept, the block SHALL register:
- pass = (final sum == 16'hFFFF);
- bits_out = ~final sum;
- word_cnt and len_ovf.
REQ-022 These registered values SHALL hold until the next final accept.
REQ-023 REPORT SHALL last exactly one cycle, with done=1; the next state SHALL be IDLE and acc SHALL be cleared.
REQ-024 Latency: done SHALL be asserted in the cycle immediately after the edge at which the last word is accepted.
REQ-025 Maximum throughput SHALL be one packet every N+1 cycles for an N-word packet.
REQ-026 Word count SHALL saturate at 2^LEN_W-1; when a packet exceeds this, len_ovf=1 and pass is forced to 0 for that packet.
REQ-027 A single-word packet SHALL be legal; its verdict is pass = (word == 16'hFFFF).
REQ-028 A final sum of 16'h0000 SHALL report a fail; no negative-zero equivalence is applied.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL set:
- state = IDLE, acc = 0, count = 0;
- done = 0, pass = 0, bits_out = 16'h0000, word_cnt = 0, len_ovf = 0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet with no done pulse; the first accepted word after reset SHALL start a new packet.
REQ-031 bits_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-032 Macro CHECKSUM16_ERRCNT_EN: when defined, the block SHALL add port err_cnt (output, 8 bits).
REQ-033 err_cnt SHALL count REPORT cycles with pass=0, saturate at 255, and reset to 0.
REQ-034 Without CHECKSUM16_ERRCNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Words 16'h1234, 16'h5678, 16'h9753(last), back-to-back -> done one cycle later; pass=1, bits_out=16'h0000, word_cnt=3.
REQ-036 Words 16'hFFFF, 16'h0001, 16'hFFFE(last) -> end-around carry exercised; pass=1, bits_out=16'h0000.
REQ-037 Words 16'h1234, 16'h5679, 16'h9753(last) -> pass=0, bits_out=16'hFFFE; err_cnt increments by 1 when the macro is defined.
REQ-038 bits_valid toggling 1/0 across the packet of REQ-035, plus a valid word offered during REPORT -> the REPORT-cycle word is not accepted; the verdict is identical to REQ-035.
REQ-039 rst_n=0 for one cycle after two words of a packet, then a full REQ-035 packet -> no done for the aborted packet; the second packet reports pass=1, word_cnt=3.
REQ-040 LEN_W=2, 4-word packet with a correct checksum -> word_cnt=3 (saturated), len_ovf=1, pass=0.

Source files
------------

// File: rtl/checksum16_verify.sv
// One's-complement (RFC 1071 style) packet checksum verifier: folds each packet and reports pass/fail.
// Optional feature: define CHECKSUM16_ERRCNT_EN to add the saturating err_cnt output.
module checksum16_verify #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      bits_in,
    input  logic             bits_valid,
    input  logic             bits_last,
    output logic             bits_ready,
    output logic             done,
    output logic             pass,
    output logic [15:0]      bits_out,
    output logic [LEN_W-1:0] word_cnt,
`ifdef CHECKSUM16_ERRCNT_EN
    output logic             len_ovf,
    output logic [7:0]       err_cnt
`else
    output logic             len_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t            state, state_nxt;
    logic [15:0]       acc, acc_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic              ovf, ovf_nxt;
    logic              accept;
    logic              final_accept;
    logic [16:0]       sum17;
    logic [15:0]       oc_sum;

    assign accept = bits_valid && bits_ready;

    // End-around carry folded in the same cycle; the result cannot exceed 16'hFFFF.
    assign sum17  = {1'b0, acc} + {1'b0, bits_in};
    assign oc_sum = sum17[15:0] + {15'b0, sum17[16]};

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        ovf_nxt      = ovf;
        bits_ready   = 1'b0;
        done         = 1'b0;
        final_accept = 1'b0;
        case (state)
            IDLE: begin
                bits_ready = 1'b1;
                if (accept) begin
                    acc_nxt      = bits_in;
                    cnt_nxt      = CNT_ONE;
                    ovf_nxt      = 1'b0;
                    final_accept = bits_last;
                    state_nxt    = bits_last ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                bits_ready = 1'b1;
                if (accept) begin
                    acc_nxt = oc_sum;
                    if (cnt == CNT_MAX) ovf_nxt = 1'b1;
                    else                cnt_nxt = cnt + CNT_ONE;
                    final_accept = bits_last;
                    state_nxt    = bits_last ? REPORT : ACCUM;
                end
            end
            REPORT: begin
                done      = 1'b1;
                acc_nxt   = 16'h0000;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 16'h0000;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Verdict registers hold until the next packet's final word is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass     <= 1'b0;
            bits_out <= 16'h0000;
            word_cnt <= '0;
            len_ovf  <= 1'b0;
        end else if (final_accept) begin
            pass     <= (acc_nxt == 16'hFFFF) && !ovf_nxt;
            bits_out <= ~acc_nxt;
            word_cnt <= cnt_nxt;
            len_ovf  <= ovf_nxt;
        end
    end

`ifdef CHECKSUM16_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt <= 8'h00;
        else if (state == REPORT && !pass && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'h01;
    end
`endif

endmodule
